// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: widths, default PC step, fetch FSM states,
// and the prefetch buffer entry layout.
package cpu_pkg;

    localparam int INS_W  = 21;
    localparam int ADDR_W = 8;
    localparam logic [ADDR_W-1:0] PC_STEP_DEF = 8'd4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [INS_W-1:0]  ins;
        logic [ADDR_W-1:0] pc;
    } entry_t;

endpackage

// File: rtl/pf_fifo.sv
// Prefetch instruction buffer: DEPTH-entry circular FIFO of {ins, pc}.
// Flush wins over push/pop; head entry is exposed combinationally.
module pf_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  entry_t      din,
    output entry_t      head,
    output logic [AW:0] count
);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Guard against underflow/overflow so a stray request cannot corrupt count
    assign do_push = push && (count != (AW+1)'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    // Pointer, count and storage update; storage cleared so outputs are 0 in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ins_prefetch.sv
// Instruction prefetcher: single-outstanding memory fetch FSM feeding pf_fifo.
// Optional macro INS_PREFETCH_BYPASS_EN forwards a returning word straight to
// the outputs when the buffer is empty.
module ins_prefetch
    import cpu_pkg::*;
#(
    parameter int                DEPTH   = 4,
    parameter logic [ADDR_W-1:0] PC_STEP = PC_STEP_DEF,
    localparam int               CW      = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INS_W-1:0]  mem_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall,
    output logic              ins_valid,
    output logic [INS_W-1:0]  ins_out,
    output logic [ADDR_W-1:0] ins_pc,
    output logic [ADDR_W-1:0] ins_npc
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [CW-1:0]     count;
    entry_t            head;
    logic              accept;
    logic              push;
    logic              pop;

    // A returning word is kept only in WAIT and only if no redirect kills it
    assign accept = (state == WAIT) && mem_ack && !redirect;
    assign pop    = (count != '0) && !stall && !redirect;

`ifdef INS_PREFETCH_BYPASS_EN
    logic bypass;
    assign bypass    = accept && (count == '0);
    // A bypassed word consumed this cycle never enters storage
    assign push      = accept && !(bypass && !stall);
    assign ins_valid = (count != '0) || bypass;
    assign ins_out   = bypass ? mem_data : head.ins;
    assign ins_pc    = bypass ? fetch_pc : head.pc;
`else
    assign push      = accept;
    assign ins_valid = (count != '0);
    assign ins_out   = head.ins;
    assign ins_pc    = head.pc;
`endif
    assign ins_npc = ins_pc + PC_STEP;

    pf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   ('{ins: mem_data, pc: fetch_pc}),
        .head  (head),
        .count (count)
    );

    // Fetch FSM: one request in flight; a free slot is reserved before issuing,
    // and pushes only happen for the in-flight request, so storage never overflows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        // Buffer is flushed this cycle, so restart at once
                        fetch_pc <= redirect_pc;
                        mem_req  <= 1'b1;
                        mem_addr <= redirect_pc;
                        state    <= WAIT;
                    end else if (count < CW'(DEPTH)) begin
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                        mem_req  <= 1'b0;
                        // Without the ack the old word is still coming and must be eaten
                        state    <= mem_ack ? IDLE : DROP;
                    end else if (mem_ack) begin
                        fetch_pc <= fetch_pc + PC_STEP;
                        mem_req  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                DROP: begin
                    if (redirect) fetch_pc <= redirect_pc;
                    // The stale ack completes the abandoned request
                    if (mem_ack) state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ins_prefetch.sv
// Scoreboard bench for ins_prefetch: directed scenarios push expected head
// entries, a monitor compares every consumed entry, a responder acks requests.
module tb_ins_prefetch;
    import cpu_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [INS_W-1:0]  mem_data;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              stall;
    logic              ins_valid;
    logic [INS_W-1:0]  ins_out;
    logic [ADDR_W-1:0] ins_pc;
    logic [ADDR_W-1:0] ins_npc;

    typedef struct {
        logic [INS_W-1:0]  ins;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] npc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   budget = 0;
    int   used   = 0;
    logic             man_ack  = 1'b0;
    logic [INS_W-1:0] man_data = '0;

    ins_prefetch #(.DEPTH(4), .PC_STEP(8'd4)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .redirect(redirect),
        .redirect_pc(redirect_pc), .stall(stall), .ins_valid(ins_valid),
        .ins_out(ins_out), .ins_pc(ins_pc), .ins_npc(ins_npc)
    );

    always #5 clk = ~clk;

    function automatic logic [INS_W-1:0] dat(input logic [ADDR_W-1:0] a);
        return {5'h15, a, ~a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act %h exp %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] npc);
        exp_q.push_back('{dat(pc), pc, npc});
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!mem_req && n < 50) begin tick(); n++; end
        chk(name, 32'(mem_req), 32'd1);
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0; redirect = 1'b0; stall = 1'b0; man_ack = 1'b0; budget = used;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Memory responder: zero-latency ack while budget remains, or a forced ack
    initial begin
        mem_ack = 1'b0; mem_data = '0;
        forever begin
            @(posedge clk); #2;
            mem_ack = 1'b0;
            if (rst_n && man_ack) begin
                mem_ack = 1'b1; mem_data = man_data;
            end else if (rst_n && mem_req && used < budget) begin
                mem_ack = 1'b1; mem_data = dat(mem_addr); used++;
            end
        end
    end

    // Monitor: every entry consumed by the pipeline must match the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ins_valid && !stall && !redirect) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected act pc %h ins %h exp none", ins_pc, ins_out);
                end else begin
                    e = exp_q.pop_front();
                    if (ins_out !== e.ins || ins_pc !== e.pc || ins_npc !== e.npc) begin
                        errors++;
                        $display("FAIL pop act %h/%h/%h exp %h/%h/%h",
                                 ins_out, ins_pc, ins_npc, e.ins, e.pc, e.npc);
                    end
                end
            end
        end
    end

    initial begin
        int base;
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
        repeat (2) tick();
        // Reset values
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_ins_valid", 32'(ins_valid), 0);
        chk("rst_ins_out", 32'(ins_out), 0);
        chk("rst_ins_pc", 32'(ins_pc), 0);
        chk("rst_ins_npc", 32'(ins_npc), 32'h04);

        // Sequential fetch from 0x00 after release
        rst_n = 1'b1;
        budget = used + 3;
        push_exp(8'h00, 8'h04); push_exp(8'h04, 8'h08); push_exp(8'h08, 8'h0C);
        tick();
        chk("first_req", 32'(mem_req), 1);
        chk("first_addr", 32'(mem_addr), 0);
        wait_empty("seq_drain");

        // Stall fills the buffer to DEPTH and halts requests
        do_reset();
        stall = 1'b1;
        base = used;
        budget = used + 6;
        push_exp(8'h00, 8'h04); push_exp(8'h04, 8'h08); push_exp(8'h08, 8'h0C);
        push_exp(8'h0C, 8'h10); push_exp(8'h10, 8'h14); push_exp(8'h14, 8'h18);
        repeat (12) tick();
        chk("full_acks", used - base, 4);
        chk("full_req_low", 32'(mem_req), 0);
        chk("full_head_pc", 32'(ins_pc), 0);
        repeat (3) tick();
        chk("full_req_still_low", 32'(mem_req), 0);
        stall = 1'b0;
        wait_empty("stall_drain");

        // Redirect while waiting: old word dropped, restart at 0x40
        do_reset();
        wait_req("redir_req");
        redirect = 1'b1; redirect_pc = 8'h40;
        tick();
        redirect = 1'b0;
        chk("drop_req_low", 32'(mem_req), 0);
        chk("drop_valid_low", 32'(ins_valid), 0);
        tick(); tick();
        man_ack = 1'b1; man_data = dat(8'h00);
        tick();
        man_ack = 1'b0;
        budget = used + 1;
        push_exp(8'h40, 8'h44);
        chk("drop_valid_low2", 32'(ins_valid), 0);
        tick();
        chk("redir_req_again", 32'(mem_req), 1);
        chk("redir_addr", 32'(mem_addr), 32'h40);
        wait_empty("redir_drain");

        // Redirect to 0xF8 with wrap-around
        do_reset();
        redirect = 1'b1; redirect_pc = 8'hF8;
        budget = used + 3;
        push_exp(8'hF8, 8'hFC); push_exp(8'hFC, 8'h00); push_exp(8'h00, 8'h04);
        tick();
        redirect = 1'b0;
        chk("wrap_req", 32'(mem_req), 1);
        chk("wrap_addr", 32'(mem_addr), 32'hF8);
        wait_empty("wrap_drain");

        // Reset mid-request; late ack after release must be ignored
        do_reset();
        wait_req("rst_mid_req");
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1; man_ack = 1'b1; man_data = 21'h1FFFF;
        tick();
        man_ack = 1'b0;
        chk("late_ack_valid", 32'(ins_valid), 0);
        chk("late_req", 32'(mem_req), 1);
        chk("late_addr", 32'(mem_addr), 0);
        budget = used + 1;
        push_exp(8'h00, 8'h04);
        wait_empty("late_drain");

        // Ack-to-valid latency on an empty buffer
        do_reset();
        wait_req("lat_req");
        exp_q.push_back('{21'h1ABCD, 8'h00, 8'h04});
        man_ack = 1'b1; man_data = 21'h1ABCD;
        @(negedge clk);
`ifdef INS_PREFETCH_BYPASS_EN
        chk("lat_valid_same", 32'(ins_valid), 1);
        chk("lat_out_same", 32'(ins_out), 32'h1ABCD);
`else
        chk("lat_valid_same", 32'(ins_valid), 0);
`endif
        tick();
        man_ack = 1'b0;
        @(negedge clk);
`ifdef INS_PREFETCH_BYPASS_EN
        chk("lat_valid_next", 32'(ins_valid), 0);
`else
        chk("lat_valid_next", 32'(ins_valid), 1);
        chk("lat_out_next", 32'(ins_out), 32'h1ABCD);
`endif
        wait_empty("lat_drain");

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ins_prefetch.md
INS_PREFETCH -- requirements
Module: ins_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered instruction entries (power of two, 2..8).
REQ-002 Parameter PC_STEP, default 4, byte increment between sequential fetch addresses.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 mem_req  output  1  instruction-memory request valid.
REQ-006 mem_addr  output  8  fetch address; stable while mem_req high.
REQ-007 mem_ack  input  1  one-cycle pulse: mem_data valid, request complete.
REQ-008 mem_data  input  21  returned instruction word.
REQ-009 redirect  input  1  branch/jump taken; flush and restart at redirect_pc.
REQ-010 redirect_pc  input  8  new fetch address, sampled when redirect high.
REQ-011 stall  input  1  consumer (IF/ID) holding; head entry not consumed.
REQ-012 ins_valid  output  1  head entry valid.
REQ-013 ins_out  output  21  head instruction.
REQ-014 ins_pc  output  8  address of head instruction.
REQ-015 ins_npc  output  8  ins_pc + PC_STEP, modulo 256.

Function
REQ-016 FSM states IDLE, WAIT, DROP; at most one memory request outstanding.
REQ-017 IDLE: if free slots (DEPTH - count) >= 1 and no redirect, assert mem_req with mem_addr = fetch_pc, go WAIT.
REQ-018 WAIT: hold mem_req and mem_addr; on mem_ack push {mem_data, fetch_pc}, fetch_pc += PC_STEP (8-bit wrap, 0xFC -> 0x00), go IDLE.
REQ-019 Slot reservation: a request is issued only if a slot is free counting the outstanding request, so a push never overflows.
REQ-020 Pop when ins_valid = 1 and stall = 0; push and pop in the same cycle leave count unchanged.
REQ-021 ins_valid = (count != 0); ins_out, ins_pc, ins_npc reflect the head entry, combinational from storage.
REQ-022 redirect (highest priority): count <= 0, fetch_pc <= redirect_pc, any same-cycle push or pop discarded.
REQ-023 redirect in WAIT without mem_ack -> DROP (mem_req deasserted); the next mem_ack is discarded, then IDLE.
REQ-024 redirect in WAIT with same-cycle mem_ack -> data discarded, IDLE.
REQ-025 redirect in DROP: fetch_pc updated to newest redirect_pc, remain DROP.
REQ-026 Latency: mem_ack to ins_valid = 1 cycle (empty buffer, macro off); redirect to first mem_req = 1 cycle when no request is outstanding.

Reset
REQ-027 rst_n low: state IDLE, fetch_pc 0x00, count 0, pointers 0; mem_req 0, mem_addr 0x00, ins_valid 0, ins_out 0, ins_pc 0x00, ins_npc 0x04.
REQ-028 Reset asserted mid-request: outstanding request abandoned; a mem_ack arriving after release while in IDLE is ignored.
REQ-029 First mem_req (addr 0x00) asserted in the first cycle after rst_n deasserts.

Configuration
REQ-030 Macro INS_PREFETCH_BYPASS_EN: when defined, if count = 0 and mem_ack = 1 (no redirect), ins_valid/ins_out/ins_pc are driven from mem_data/fetch_pc in the same cycle, and the entry is not pushed if popped that cycle.
REQ-031 Without INS_PREFETCH_BYPASS_EN, outputs come only from storage (REQ-026 latency).

Structure
REQ-032 Shared package cpu_pkg holds INS_W = 21, ADDR_W = 8, default PC_STEP, and the fetch-state enum {IDLE, WAIT, DROP}.
REQ-033 Storage is one sub-module pf_fifo (DEPTH x (INS_W + ADDR_W), push/pop/flush, count output); FSM and PC logic stay in ins_prefetch.

Verification
REQ-034 Reset release, mem_ack 1 cycle after each req, stall = 0 -> ins_pc sequence 0x00, 0x04, 0x08; ins_npc 0x04, 0x08, 0x0C.
REQ-035 stall held high for 10 cycles -> exactly DEPTH = 4 entries buffered, mem_req low while full, no entry lost after stall drops.
REQ-036 redirect to 0x40 while WAIT, ack 3 cycles later -> that word dropped, next mem_addr 0x40, ins_valid low until it returns.
REQ-037 redirect_pc 0xF8, continuous acks -> ins_pc 0xF8, 0xFC, 0x00 (wrap).
REQ-038 rst_n pulsed low while WAIT, late mem_ack after release -> ignored; first ins_pc 0x00.
REQ-039 Macro defined, empty buffer, mem_ack with data 0x1ABCD -> ins_valid and ins_out = 0x1ABCD in the same cycle; macro undefined -> one cycle later.
